centroid_tracker: RTL and testbench

CENTROID_TRACKER -- requirements
Module: centroid_tracker

---
 rtl/centroid_tracker_pkg.sv | 31 +++
 rtl/centroid_axis_filter.sv | 43 ++++
 rtl/centroid_tracker.sv | 157 +++++++++++++++
 tb/tb_centroid_tracker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/centroid_tracker_pkg.sv
// Shared definitions for the centroid tracker: tracker state encoding,
// coordinate widths, default tuning parameters and the per-frame request
// bundle.
package centroid_tracker_pkg;

   localparam int X_W    = 10;  // x coordinate width
   localparam int Y_W    = 9;   // y coordinate width
   localparam int DIFF_W = 11;  // signed difference width, wide enough for either axis

   localparam int DEF_IMG_WIDTH   = 640;
   localparam int DEF_IMG_HEIGHT  = 480;
   localparam int DEF_ACQ_FRAMES  = 3;
   localparam int DEF_LOST_FRAMES = 5;
   localparam int DEF_ALPHA_SHIFT = 2;
   localparam int DEF_MAX_JUMP    = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2,
      ST_COAST   = 2'd3
   } trk_state_t;

   // One end-of-frame measurement as seen by the tracker.
   typedef struct packed {
      logic           valid;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } frame_t;

endpackage

// File: rtl/centroid_axis_filter.sv
// Per-axis measurement filter. Compares a raw centroid coordinate with a
// reference coordinate and produces the smoothed coordinate.
//   raw       : raw coordinate of the current frame
//   ref_pos   : reference (acquisition candidate or tracked position)
//   in_range  : |raw - ref_pos| <= MAX_JUMP
//   smoothed  : ref_pos + floor((raw - ref_pos) / 2^ALPHA_SHIFT), clamped to 0..LIMIT-1
module centroid_axis_filter
   import centroid_tracker_pkg::*;
#(
   parameter int W           = X_W,
   parameter int LIMIT       = DEF_IMG_WIDTH,
   parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT,
   parameter int MAX_JUMP    = DEF_MAX_JUMP
) (
   input  logic [W-1:0] raw,
   input  logic [W-1:0] ref_pos,
   output logic         in_range,
   output logic [W-1:0] smoothed
);

   logic signed [DIFF_W-1:0] diff;
   logic signed [DIFF_W-1:0] mag;
   logic signed [DIFF_W-1:0] step;
   logic signed [DIFF_W:0]   sum;

   always_comb begin
      // Both operands are zero-extended, so the 11-bit result never wraps.
      diff     = $signed({{(DIFF_W-W){1'b0}}, raw}) - $signed({{(DIFF_W-W){1'b0}}, ref_pos});
      mag      = diff[DIFF_W-1] ? -diff : diff;
      in_range = (int'(mag) <= MAX_JUMP);
      // Arithmetic shift rounds toward minus infinity for negative steps.
      step     = diff >>> ALPHA_SHIFT;
      sum      = $signed({{(DIFF_W+1-W){1'b0}}, ref_pos}) + $signed({step[DIFF_W-1], step});
      // The update is convex, so these clamps only guard against misuse.
      if (sum[DIFF_W])
         smoothed = '0;
      else if (int'(sum) > LIMIT - 1)
         smoothed = W'(LIMIT - 1);
      else
         smoothed = sum[W-1:0];
   end

endmodule

// File: rtl/centroid_tracker.sv
// Frame-rate centroid tracker. Acquires an object after ACQ_FRAMES consistent
// detections, smooths the tracked position while locked, coasts through
// short dropouts and drops lock after LOST_FRAMES consecutive misses.
//   i_clk, i_rstn         : clock, synchronous active-low reset
//   i_end_frame           : one-cycle strobe; centroid inputs sampled here
//   i_centroid_x/y        : raw frame centroid
//   i_red_object_valid    : frame contained a qualifying object
//   o_x, o_y              : tracked position
//   o_lock                : state is TRACK or COAST
//   o_update              : pulse in the cycle after each processed frame
//   o_state               : IDLE=0, ACQUIRE=1, TRACK=2, COAST=3
//   o_miss_count          : consecutive misses while coasting, saturating at 7
module centroid_tracker
   import centroid_tracker_pkg::*;
#(
   parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
   parameter int ACQ_FRAMES  = DEF_ACQ_FRAMES,
   parameter int LOST_FRAMES = DEF_LOST_FRAMES,
   parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT,
   parameter int MAX_JUMP    = DEF_MAX_JUMP
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_end_frame,
   input  logic [X_W-1:0] i_centroid_x,
   input  logic [Y_W-1:0] i_centroid_y,
   input  logic           i_red_object_valid,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_lock,
   output logic           o_update,
   output logic [1:0]     o_state,
   output logic [2:0]     o_miss_count
);

   localparam int HC_W = $clog2(ACQ_FRAMES + 1);
   localparam int MC_W = $clog2(LOST_FRAMES + 1);

   frame_t           frm;
   trk_state_t       state;
   logic [X_W-1:0]   cand_x, ref_x, sm_x;
   logic [Y_W-1:0]   cand_y, ref_y, sm_y;
   logic [HC_W-1:0]  hit_cnt;
   logic [MC_W-1:0]  miss_cnt;
   logic             x_in, y_in, hit, last_hit, last_miss;

   assign frm = '{valid: i_red_object_valid, x: i_centroid_x, y: i_centroid_y};

   // During acquisition frames are compared with the previous candidate,
   // otherwise with the tracked position.
   assign ref_x = (state == ST_ACQUIRE) ? cand_x : o_x;
   assign ref_y = (state == ST_ACQUIRE) ? cand_y : o_y;

   centroid_axis_filter #(
      .W(X_W), .LIMIT(IMG_WIDTH), .ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)
   ) u_filt_x (
      .raw(frm.x), .ref_pos(ref_x), .in_range(x_in), .smoothed(sm_x)
   );

   centroid_axis_filter #(
      .W(Y_W), .LIMIT(IMG_HEIGHT), .ALPHA_SHIFT(ALPHA_SHIFT), .MAX_JUMP(MAX_JUMP)
   ) u_filt_y (
      .raw(frm.y), .ref_pos(ref_y), .in_range(y_in), .smoothed(sm_y)
   );

   assign hit       = frm.valid && x_in && y_in;
   assign last_hit  = (int'(hit_cnt) + 1 >= ACQ_FRAMES);
   assign last_miss = (int'(miss_cnt) + 1 >= LOST_FRAMES);

   assign o_state      = state;
   assign o_lock       = (state == ST_TRACK) || (state == ST_COAST);
   assign o_miss_count = (int'(miss_cnt) > 7) ? 3'd7 : 3'(miss_cnt);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state    <= ST_IDLE;
         o_x      <= '0;
         o_y      <= '0;
         o_update <= 1'b0;
         cand_x   <= '0;
         cand_y   <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         o_update <= i_end_frame;
         if (i_end_frame) begin
            case (state)
               ST_IDLE: begin
                  if (frm.valid) begin
                     cand_x <= frm.x;
                     cand_y <= frm.y;
                     if (ACQ_FRAMES == 1) begin
                        state   <= ST_TRACK;
                        o_x     <= frm.x;
                        o_y     <= frm.y;
                        hit_cnt <= '0;
                     end else begin
                        state   <= ST_ACQUIRE;
                        hit_cnt <= HC_W'(1);
                     end
                  end
               end
               ST_ACQUIRE: begin
                  if (hit) begin
                     cand_x <= frm.x;
                     cand_y <= frm.y;
                     if (last_hit) begin
                        state   <= ST_TRACK;
                        o_x     <= frm.x;
                        o_y     <= frm.y;
                        hit_cnt <= '0;
                     end else begin
                        hit_cnt <= hit_cnt + HC_W'(1);
                     end
                  end else if (frm.valid) begin
                     // Object jumped: restart acquisition around the new position.
                     cand_x  <= frm.x;
                     cand_y  <= frm.y;
                     hit_cnt <= HC_W'(1);
                  end else begin
                     state   <= ST_IDLE;
                     hit_cnt <= '0;
                  end
               end
               ST_TRACK: begin
                  if (hit) begin
                     o_x <= sm_x;
                     o_y <= sm_y;
                  end else if (LOST_FRAMES == 1) begin
                     state    <= ST_IDLE;
                     miss_cnt <= '0;
                  end else begin
                     state    <= ST_COAST;
                     miss_cnt <= MC_W'(1);
                  end
               end
               ST_COAST: begin
                  if (hit) begin
                     o_x      <= sm_x;
                     o_y      <= sm_y;
                     miss_cnt <= '0;
                     state    <= ST_TRACK;
                  end else if (last_miss) begin
                     state    <= ST_IDLE;
                     miss_cnt <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + MC_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker. Two instances share the stimulus:
// "d" uses default parameters, "w" widens MAX_JUMP to 128 so that 100 px
// smoothing steps count as hits.
module tb_centroid_tracker;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_end_frame = 1'b0;
   logic [9:0] i_centroid_x = '0;
   logic [8:0] i_centroid_y = '0;
   logic       i_red_object_valid = 1'b0;

   logic [9:0] d_x, w_x;
   logic [8:0] d_y, w_y;
   logic       d_lock, w_lock, d_upd, w_upd;
   logic [1:0] d_state, w_state;
   logic [2:0] d_miss, w_miss;

   int total = 0;
   int passed = 0;

   always #5 i_clk = ~i_clk;

   centroid_tracker dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_end_frame(i_end_frame),
      .i_centroid_x(i_centroid_x), .i_centroid_y(i_centroid_y),
      .i_red_object_valid(i_red_object_valid),
      .o_x(d_x), .o_y(d_y), .o_lock(d_lock), .o_update(d_upd),
      .o_state(d_state), .o_miss_count(d_miss)
   );

   centroid_tracker #(.MAX_JUMP(128)) dut_w (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_end_frame(i_end_frame),
      .i_centroid_x(i_centroid_x), .i_centroid_y(i_centroid_y),
      .i_red_object_valid(i_red_object_valid),
      .o_x(w_x), .o_y(w_y), .o_lock(w_lock), .o_update(w_upd),
      .o_state(w_state), .o_miss_count(w_miss)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Present one frame; strobe stays high so back-to-back calls are consecutive strobes.
   task automatic frame(input logic v, input int x, input int y);
      @(negedge i_clk);
      i_end_frame        = 1'b1;
      i_red_object_valid = v;
      i_centroid_x       = 10'(x);
      i_centroid_y       = 9'(y);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input logic v, input int x);
      @(negedge i_clk);
      i_end_frame        = 1'b0;
      i_red_object_valid = v;
      i_centroid_x       = 10'(x);
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rstn      = 1'b0;
      i_end_frame = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rstn = 1'b1;
   endtask

   task automatic acquire(input int x, input int y);
      repeat (3) frame(1'b1, x, y);
      idle(1'b0, 0);
   endtask

   initial begin
      // Reset state
      do_reset();
      #1;
      chk("rst_x", d_x, 0);
      chk("rst_y", d_y, 0);
      chk("rst_lock", d_lock, 0);
      chk("rst_upd", d_upd, 0);
      chk("rst_state", d_state, 0);
      chk("rst_miss", d_miss, 0);

      // Acquisition over three consecutive strobes
      frame(1'b1, 320, 240);
      chk("acq1_state", d_state, 1);
      chk("acq1_upd", d_upd, 1);
      frame(1'b1, 320, 240);
      chk("acq2_state", d_state, 1);
      chk("acq2_upd", d_upd, 1);
      frame(1'b1, 320, 240);
      chk("acq3_state", d_state, 2);
      chk("acq3_lock", d_lock, 1);
      chk("acq3_x", d_x, 320);
      chk("acq3_y", d_y, 240);
      chk("acq3_upd", d_upd, 1);

      // No strobe: inputs ignored, o_update drops
      idle(1'b1, 5);
      chk("idle_upd", d_upd, 0);
      chk("idle_state", d_state, 2);
      chk("idle_x", d_x, 320);

      // Jump too large -> coast
      frame(1'b1, 500, 240);
      chk("jump_state", d_state, 3);
      chk("jump_miss", d_miss, 1);
      chk("jump_x", d_x, 320);
      chk("jump_lock", d_lock, 1);

      // Back in range from COAST
      frame(1'b1, 320, 240);
      chk("recov_state", d_state, 2);
      chk("recov_miss", d_miss, 0);

      // Diff exactly MAX_JUMP is a hit: 320 + 64/4
      frame(1'b1, 384, 240);
      chk("edge64_state", d_state, 2);
      chk("edge64_x", d_x, 336);

      // Diff MAX_JUMP+1 is a miss
      frame(1'b1, 401, 240);
      chk("edge65_state", d_state, 3);
      chk("edge65_x", d_x, 336);

      frame(1'b1, 336, 240);
      chk("retrack_state", d_state, 2);

      // Five empty frames drop lock
      for (int i = 1; i <= 4; i++) begin
         frame(1'b0, 0, 0);
         chk($sformatf("lost%0d_state", i), d_state, 3);
         chk($sformatf("lost%0d_miss", i), d_miss, i);
      end
      frame(1'b0, 0, 0);
      chk("lost5_state", d_state, 0);
      chk("lost5_lock", d_lock, 0);
      chk("lost5_x", d_x, 336);
      chk("lost5_y", d_y, 240);
      idle(1'b0, 0);

      // Floor rounding of negative steps: -1 >>> 2 = -1
      acquire(320, 240);
      frame(1'b1, 319, 239);
      chk("floor_x", d_x, 319);
      chk("floor_y", d_y, 239);
      idle(1'b0, 0);

      // Smoothing by 1/4 with a wide jump window
      do_reset();
      acquire(100, 50);
      chk("w_lock100", w_x, 100);
      frame(1'b1, 200, 50);
      chk("w_up_x", w_x, 125);
      chk("w_up_upd", w_upd, 1);
      idle(1'b0, 0);
      chk("w_up_upd_off", w_upd, 0);
      do_reset();
      acquire(200, 50);
      frame(1'b1, 100, 50);
      chk("w_down_x", w_x, 175);
      chk("w_down_upd", w_upd, 1);
      idle(1'b0, 0);
      chk("w_down_upd_off", w_upd, 0);

      // Out-of-range object during ACQUIRE restarts the count at 1
      do_reset();
      frame(1'b1, 300, 200);
      frame(1'b1, 300, 200);
      frame(1'b1, 400, 200);
      chk("restart_state", d_state, 1);
      frame(1'b1, 400, 200);
      chk("restart_cnt2", d_state, 1);
      frame(1'b1, 400, 200);
      chk("restart_lock_state", d_state, 2);
      chk("restart_lock_x", d_x, 400);

      // Reset wins over a simultaneous strobe
      @(negedge i_clk);
      i_rstn             = 1'b0;
      i_end_frame        = 1'b1;
      i_red_object_valid = 1'b1;
      i_centroid_x       = 10'd410;
      @(posedge i_clk);
      #1;
      chk("rstf_x", d_x, 0);
      chk("rstf_y", d_y, 0);
      chk("rstf_lock", d_lock, 0);
      chk("rstf_upd", d_upd, 0);
      chk("rstf_state", d_state, 0);
      chk("rstf_miss", d_miss, 0);
      @(negedge i_clk);
      i_end_frame = 1'b0;
      i_rstn      = 1'b1;
      @(posedge i_clk);
      #1;
      chk("rstf_after_state", d_state, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
